// File: rtl/pb_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : pb_conditioner
//  Description : Multi-channel push-button conditioner. Each channel passes
//                its raw button through an optional inversion and a
//                SYNC_STAGES-deep synchroniser, then debounces the result.
//                It produces a debounced level, one-cycle press and release
//                pulses, and an auto-repeat pulse train while the button is
//                held.
//
//  Ports       : clk        - single clock, rising edge
//                rst_n      - synchronous active-low reset
//                pb         - [N] raw asynchronous button inputs
//                repeat_en  - global auto-repeat enable
//                pb_level   - [N] debounced level (1 = pressed)
//                pb_press   - [N] one-cycle pulse on debounced 0->1
//                pb_release - [N] one-cycle pulse on debounced 1->0
//                pb_repeat  - [N] one-cycle auto-repeat pulse while held
//                any_press  - OR of pb_press, same cycle
//
//  Revision    : 1.0 - initial release
// ============================================================================
module pb_conditioner #(
    parameter int N               = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] pb,
    input  logic         repeat_en,
    output logic [N-1:0] pb_level,
    output logic [N-1:0] pb_press,
    output logic [N-1:0] pb_release,
    output logic [N-1:0] pb_repeat,
    output logic         any_press
);

    localparam int c_db_w      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int c_tmr_max   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_tmr_w     = $clog2(c_tmr_max) + 1;

    localparam logic [c_db_w-1:0]  c_db_last     = c_db_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_delay_last  = c_tmr_w'(REPEAT_DELAY - 1);
    localparam logic [c_tmr_w-1:0] c_period_last = c_tmr_w'(REPEAT_PERIOD - 1);

    // Repeat FSM encoding
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_delay  = 2'd1;
    localparam logic [1:0] c_st_repeat = 2'd2;

    // Inversion happens before the synchroniser so that reset (all flops 0)
    // always means "not pressed", whatever the button polarity.
    logic [N-1:0] w_pb_in;
    logic [N-1:0] w_press_nxt;
    logic         r_any_press;

    assign w_pb_in = (ACTIVE_LOW != 0) ? ~pb : pb;

    generate
        for (genvar i = 0; i < N; i++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            logic [c_db_w-1:0]      r_db_cnt;
            logic                   r_level;
            logic                   r_press;
            logic                   r_release;
            logic                   r_repeat;
            logic [1:0]             r_state;
            logic [c_tmr_w-1:0]     r_tmr;

            logic w_sync;
            logic w_diff;
            logic w_toggle;
            logic w_level_nxt;

            assign w_sync      = r_sync[SYNC_STAGES-1];
            assign w_diff      = w_sync ^ r_level;
            // Level flips on the edge where the mismatch has been seen for
            // DEBOUNCE_CYCLES consecutive edges.
            assign w_toggle    = w_diff && (r_db_cnt == c_db_last);
            assign w_level_nxt = r_level ^ w_toggle;

            assign w_press_nxt[i] = w_toggle & ~r_level;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_sync    <= '0;
                    r_db_cnt  <= '0;
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                    r_repeat  <= 1'b0;
                    r_state   <= c_st_idle;
                    r_tmr     <= '0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], w_pb_in[i]};

                    // Any agreement between input and level restarts the count,
                    // so a glitch shorter than the debounce window is ignored.
                    if (!w_diff || w_toggle) begin
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end

                    r_level   <= w_level_nxt;
                    r_press   <= w_toggle & ~r_level;
                    r_release <= w_toggle & r_level;

                    // The FSM looks at the next level so that the release edge
                    // itself aborts repeating and can never carry a repeat pulse.
                    r_repeat <= 1'b0;
                    case (r_state)
                        c_st_idle: begin
                            // Covers both a fresh press with repeat enabled and
                            // repeat_en rising while the button is already held.
                            if (w_level_nxt && repeat_en) begin
                                r_state <= c_st_delay;
                                r_tmr   <= '0;
                            end
                        end
                        c_st_delay: begin
                            if (!w_level_nxt || !repeat_en) begin
                                r_state <= c_st_idle;
                                r_tmr   <= '0;
                            end else if (r_tmr == c_delay_last) begin
                                r_repeat <= 1'b1;
                                r_state  <= c_st_repeat;
                                r_tmr    <= '0;
                            end else begin
                                r_tmr <= r_tmr + 1'b1;
                            end
                        end
                        c_st_repeat: begin
                            if (!w_level_nxt || !repeat_en) begin
                                r_state <= c_st_idle;
                                r_tmr   <= '0;
                            end else if (r_tmr == c_period_last) begin
                                r_repeat <= 1'b1;
                                r_tmr    <= '0;
                            end else begin
                                r_tmr <= r_tmr + 1'b1;
                            end
                        end
                        default: begin
                            r_state <= c_st_idle;
                            r_tmr   <= '0;
                        end
                    endcase
                end
            end

            assign pb_level[i]   = r_level;
            assign pb_press[i]   = r_press;
            assign pb_release[i] = r_release;
            assign pb_repeat[i]  = r_repeat;
        end
    endgenerate

    // Registered from the same next-state term as pb_press so both line up.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_any_press <= 1'b0;
        end else begin
            r_any_press <= |w_press_nxt;
        end
    end

    assign any_press = r_any_press;

endmodule
`default_nettype wire

// File: doc/pb_conditioner.md
PB_CONDITIONER -- requirements
Module: pb_conditioner

Interface
REQ-001 Parameter N, default 5: number of push-button channels, range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth, range 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles for a level change, at least 1.
REQ-004 Parameter REPEAT_DELAY, default 64: cycles from press pulse to first repeat pulse, at least 1.
REQ-005 Parameter REPEAT_PERIOD, default 16: cycles between successive repeat pulses, at least 1.
REQ-006 Parameter ACTIVE_LOW, default 0: when 1, pb is inverted before synchronisation.
REQ-007 clk  input  1  single clock; all state changes on the rising edge.
REQ-008 rst_n  input  1  reset; synchronous, active-low.
REQ-009 pb  input  N  raw asynchronous button inputs.
REQ-010 repeat_en  input  1  global auto-repeat enable.
REQ-011 pb_level  output  N  debounced level, 1 means pressed.
REQ-012 pb_press  output  N  one-cycle pulse on debounced 0->1.
REQ-013 pb_release  output  N  one-cycle pulse on debounced 1->0.
REQ-014 pb_repeat  output  N  one-cycle auto-repeat pulse while held.
REQ-015 any_press  output  1  OR of pb_press, same cycle.

Function
REQ-016 Each channel shall pass pb (after optional inversion) through a SYNC_STAGES-flop synchroniser; logic after it uses only the last stage.
REQ-017 Per channel, a debounce counter of width clog2(DEBOUNCE_CYCLES)+1 shall increment on every edge where the synchronised value differs from pb_level.
REQ-018 The debounce counter shall clear on any edge where the synchronised value equals pb_level, so a glitch shorter than DEBOUNCE_CYCLES produces no change.
REQ-019 On an edge where the counter equals DEBOUNCE_CYCLES-1 and the values still differ, pb_level shall toggle and the counter shall clear.
REQ-020 Latency: a pb change first sampled at edge 1 and held steady shall update pb_level at edge SYNC_STAGES+DEBOUNCE_CYCLES.
REQ-021 pb_press and pb_release shall be registered; each is high for exactly the first cycle in which pb_level shows the new value.
REQ-022 Repeat FSM per channel, states IDLE, DELAY and REPEAT: IDLE->DELAY when pb_level toggles to 1 and repeat_en=1; the repeat timer loads 0 on that transition.
REQ-023 In DELAY the timer increments each cycle; at timer=REPEAT_DELAY-1, pb_repeat pulses for 1 cycle, the state goes to REPEAT and the timer clears.
REQ-024 In REPEAT, pb_repeat shall pulse whenever timer=REPEAT_PERIOD-1, then the timer clears; the first repeat pulse is REPEAT_DELAY cycles after pb_press, then every REPEAT_PERIOD cycles.
REQ-025 From DELAY or REPEAT: pb_level->0 or repeat_en=0 shall force IDLE and clear the timer in the same edge; no pb_repeat pulse occurs in that cycle.
REQ-026 If repeat_en rises while pb_level=1 and the state is IDLE, the FSM shall enter DELAY with the timer at 0.
REQ-027 pb_repeat and pb_press shall never be high in the same cycle on a channel.
REQ-028 Channels shall be fully independent; simultaneous events on several channels shall each produce their own pulses in the same cycle.
REQ-029 Timer width shall be clog2(max(REPEAT_DELAY, REPEAT_PERIOD))+1; no counter shall wrap while holding.

Reset
REQ-030 While rst_n=0 at an edge, all of the following shall be 0: synchroniser flops (post-inversion inactive), debounce counters, pb_level, all pulse outputs, any_press, timers; every FSM is in IDLE.
REQ-031 Reset asserted mid-debounce or mid-repeat shall abort the operation with no pulse emitted; after release a held button is re-debounced from 0 and produces a fresh pb_press.
REQ-032 With ACTIVE_LOW=1 and pb held at all-ones through reset release, no pb_press shall occur.

Verification (defaults unless stated)
REQ-033 Channel 0 pb 0->1 held -> pb_level[0]=1 and pb_press[0]=1 at edge 18, pb_press[0]=0 at edge 19, any_press=1 at edge 18 only.
REQ-034 pb[2] high for 15 edges then low -> pb_level[2], pb_press[2] and pb_release[2] stay 0 throughout.
REQ-035 repeat_en=1, pb[1] held 200 cycles -> pb_repeat[1] pulses at 64, 80, 96, ... cycles after pb_press[1]; release -> pb_release[1], no further repeats.
REQ-036 repeat_en dropped at 70 cycles after press -> no repeat at 80; re-raised while held -> next repeat exactly 64 cycles later.
REQ-037 pb[0] and pb[4] pressed same edge, rst_n=0 one cycle at press+30 -> all outputs 0 during reset; both re-press pulses occur 18 edges after release, simultaneously.
